// File: rtl/perf_pkg.sv
// perf_pkg: shared types and helpers for the pipeline performance monitor.
package perf_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CNT_CLR = 0;
    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/perf_evt_counter.sv
// perf_evt_counter: one event counter with sticky overflow.
// PERF_SAT_EN selects saturation; otherwise the counter wraps.
module perf_evt_counter import perf_pkg::*; #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    logic full;
    assign full = &cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_W'(CNT_CLR);
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= CNT_W'(CNT_CLR);
            ovf <= 1'b0;
        end else if (en && inc) begin
`ifdef PERF_SAT_EN
            cnt <= full ? cnt : cnt + CNT_W'(1);
`else
            cnt <= cnt + CNT_W'(1);
`endif
            ovf <= ovf | full;
        end
    end
endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: windowed cycle/event counters with a snapshot shadow bank.
// Define PERF_SAT_EN for saturating counters (default: wrapping).
module perf_event_monitor import perf_pkg::*; #(
    parameter  int NUM_EVT    = 4,
    parameter  int CNT_W      = 32,
    parameter  int MAX_CYCLES = 30,
    localparam int SEL_W      = sel_w(NUM_EVT)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               clr_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);
    localparam int NS = 1 << SEL_W;
    state_t           state;
    logic             cnt_en;
    logic             hit;
    logic [NUM_EVT:0] inc;
    logic [CNT_W-1:0] live   [NS];
    logic [CNT_W-1:0] shadow [NS];
    assign cnt_en  = start_i && state != DONE;
    assign inc     = {1'b1, evt_i};
    assign cycle_o = live[NUM_EVT];
    assign hit     = MAX_CYCLES != 0 && live[NUM_EVT] + CNT_W'(1) == CNT_W'(MAX_CYCLES);
    for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cnt
        perf_evt_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk(clk_i), .rst_n(rst_n_i), .clr(clr_i), .en(cnt_en),
            .inc(inc[i]), .cnt(live[i]), .ovf(ovf_o[i])
        );
    end
    // Unused select codes read permanently-zero slots, so out-of-range reads return 0.
    for (genvar i = NUM_EVT + 1; i < NS; i++) begin : g_pad
        assign live[i] = '0;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else if (clr_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else if (cnt_en) begin
            state  <= hit ? DONE : RUN;
            done_o <= hit;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NS; k++) shadow[k] <= '0;
            rd_data_o <= '0;
        end else begin
            if (snap_i) shadow <= live;
            rd_data_o <= shadow[rd_sel_i];
        end
    end
endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: directed + random stimulus against a behavioural model,
// covering a 32-bit/30-cycle instance and a 4-bit/unlimited instance in lockstep.
module tb_perf_event_monitor;
`ifdef PERF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic        clk, rst_n, start, clr, snap;
    logic [3:0]  evt;
    logic [2:0]  sel;
    logic [31:0] rd0, cyc0;
    logic [3:0]  rd1, cyc1;
    logic        done0, done1;
    logic [4:0]  ovf0, ovf1;
    int n_chk = 0, n_fail = 0;

    perf_event_monitor #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(30)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .evt_i(evt), .clr_i(clr),
        .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd0), .cycle_o(cyc0),
        .done_o(done0), .ovf_o(ovf0));
    perf_event_monitor #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .evt_i(evt), .clr_i(clr),
        .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd1), .cycle_o(cyc1),
        .done_o(done1), .ovf_o(ovf1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       mw [2] = '{32, 4};
    int       mmax [2] = '{30, 0};
    longint   cnt [2][5];
    longint   sh [2][5];
    longint   mrd [2];
    bit [4:0] mov [2];
    bit       mdone [2];

    function automatic void mreset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 5; k++) begin
                cnt[i][k] = 0;
                sh[i][k] = 0;
            end
            mrd[i] = 0;
            mov[i] = '0;
            mdone[i] = 1'b0;
        end
    endfunction

    function automatic void step(bit st, bit [3:0] ev, bit cl, bit sn, int s);
        for (int i = 0; i < 2; i++) begin
            longint top = (64'd1 << mw[i]) - 1;
            mrd[i] = (s <= 4) ? sh[i][s] : 0;
            if (sn) for (int k = 0; k < 5; k++) sh[i][k] = cnt[i][k];
            if (cl) begin
                for (int k = 0; k < 5; k++) cnt[i][k] = 0;
                mov[i] = '0;
                mdone[i] = 1'b0;
            end else if (st && !mdone[i]) begin
                for (int k = 0; k < 5; k++) begin
                    if (k == 4 || ev[k]) begin
                        if (cnt[i][k] == top) begin
                            mov[i][k] = 1'b1;
                            if (!SAT) cnt[i][k] = 0;
                        end else cnt[i][k]++;
                    end
                end
                if (mmax[i] != 0 && cnt[i][4] == mmax[i]) mdone[i] = 1'b1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare();
        check("cyc0", 64'(cyc0), cnt[0][4]);
        check("done0", 64'(done0), longint'(mdone[0]));
        check("ovf0", 64'(ovf0), longint'(mov[0]));
        check("rd0", 64'(rd0), mrd[0]);
        check("cyc1", 64'(cyc1), cnt[1][4]);
        check("done1", 64'(done1), longint'(mdone[1]));
        check("ovf1", 64'(ovf1), longint'(mov[1]));
        check("rd1", 64'(rd1), mrd[1]);
    endtask

    task automatic tick(bit st, bit [3:0] ev, bit cl, bit sn, int s);
        start = st;
        evt = ev;
        clr = cl;
        snap = sn;
        sel = 3'(s);
        @(posedge clk);
        step(st, ev, cl, sn, s);
        @(negedge clk);
        compare();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        evt = '0;
        clr = 1'b0;
        snap = 1'b0;
        sel = '0;
        mreset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare();
        check("reset_done", 64'(done0), 0);
        // Window completes after 30 counted cycles, then everything freezes.
        for (int i = 0; i < 30; i++) tick(1'b1, (i % 3 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 0);
        check("t1_cyc", 64'(cyc0), 30);
        check("t1_done", 64'(done0), 1);
        tick(1'b1, 4'b0001, 1'b0, 1'b1, 0);
        tick(1'b1, 4'b0001, 1'b0, 1'b0, 0);
        check("t1_evt0", 64'(rd0), 10);
        repeat (3) tick(1'b1, 4'hf, 1'b0, 1'b0, 4);
        check("t1_frozen", 64'(cyc0), 30);
        // Pause for 5 cycles delays done by 5.
        tick(1'b0, 4'b0000, 1'b1, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(!(i >= 10 && i < 15), 4'b0010, 1'b0, 1'b0, 1);
            if (i == 14) check("t2_hold", 64'(cyc0), 10);
            if (i == 33) check("t2_early", 64'(done0), 0);
            if (i == 34) check("t2_done", 64'(done0), 1);
        end
        // Snapshot at cycle 12 and read back every slot.
        tick(1'b0, 4'b0000, 1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) tick(1'b1, 4'($urandom), 1'b0, 1'b0, 0);
        tick(1'b0, 4'b0000, 1'b0, 1'b1, 0);
        for (int s = 0; s < 6; s++) begin
            tick(1'b0, 4'b0000, 1'b0, 1'b0, s);
            if (s == 4) check("t3_cyc_shadow", 64'(rd0), 12);
            if (s == 5) check("t3_oob", 64'(rd0), 0);
        end
        // Clear, snapshot and events on the same edge.
        tick(1'b1, 4'hf, 1'b1, 1'b1, 0);
        check("t4_cyc", 64'(cyc0), 0);
        check("t4_done", 64'(done0), 0);
        tick(1'b0, 4'b0000, 1'b0, 1'b0, 4);
        check("t4_shadow", 64'(rd0), 12);
        // Narrow counter overflow.
        for (int i = 0; i < 17; i++) tick(1'b1, 4'b0010, 1'b0, 1'b0, 0);
        tick(1'b0, 4'b0000, 1'b0, 1'b1, 1);
        tick(1'b0, 4'b0000, 1'b0, 1'b0, 1);
        check("t5_evt1", 64'(rd1), SAT ? 15 : 1);
        check("t5_ovf1", 64'(ovf1[1]), 1);
        // Asynchronous reset mid-run clears outputs before any clock edge.
        repeat (3) tick(1'b1, 4'($urandom), 1'b0, 1'b1, 4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_cyc0", 64'(cyc0), 0);
        check("t6_done0", 64'(done0), 0);
        check("t6_ovf0", 64'(ovf0), 0);
        check("t6_rd0", 64'(rd0), 0);
        check("t6_cyc1", 64'(cyc1), 0);
        check("t6_ovf1", 64'(ovf1), 0);
        check("t6_rd1", 64'(rd1), 0);
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        repeat (500)
            tick($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
